// File: rtl/pingpong_dpram.sv
// Ping-pong dual-port RAM: the producer fills one bank while the consumer drains the other.
// Banks change hands through wr_done/rd_done. Reads return through a fixed N_DELAY pipeline.
module pingpong_dpram #(
  parameter int W_DATA  = 8,
  parameter int N_WORD  = 512,
  parameter int W_WORD  = $clog2(N_WORD),
  parameter int N_DELAY = 1,
  parameter int W_BE    = W_DATA / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [W_BE-1:0]   wr_be,
  input  logic [W_WORD-1:0] wr_addr,
  input  logic [W_DATA-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [W_WORD-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_ready,
  output logic [W_DATA-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        full_cnt
);

  // Depth is rounded up to a power of two so that {sel, addr} always indexes inside the array.
  localparam int DEPTH = 2 ** (W_WORD + 1);

  logic [W_DATA-1:0] mem_q [DEPTH];

  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [1:0] full_q, full_d;

  logic [N_DELAY-1:0]             vld_q;
  logic [N_DELAY-1:0][W_DATA-1:0] dat_q;

  logic              wr_fire, rd_fire;
  logic [W_WORD:0]   wr_idx, rd_idx;
  logic [W_DATA-1:0] rd_word;

  assign wr_ready = ~full_q[wr_sel_q];
  assign rd_ready = full_q[rd_sel_q];
  assign full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  assign wr_fire = wr_en & wr_ready;
  assign rd_fire = rd_en & rd_ready;
  assign wr_idx  = {wr_sel_q, wr_addr};
  assign rd_idx  = {rd_sel_q, rd_addr};
  assign rd_word = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < W_BE; i++) begin
        if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Both handshakes may land in one cycle; they always target different banks.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (wr_done && wr_ready) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (rd_done && rd_ready) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= 2'b00;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
    end
  end

  // Data stages load only behind a valid, so rd_data holds while rd_valid is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= rd_fire;
      if (rd_fire) dat_q[0] <= rd_word;
      for (int k = 1; k < N_DELAY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign rd_valid = vld_q[N_DELAY-1];
  assign rd_data  = dat_q[N_DELAY-1];

endmodule

// File: tb/tb_pingpong_dpram.sv
// Bench for pingpong_dpram: an 8-bit/latency-1 and a 32-bit/latency-3 instance share stimulus
// and are checked against a word-array/queue model plus hand-derived expectations.
module tb_pingpong_dpram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b1;
  logic        wr_en, wr_done, rd_en, rd_done;
  logic [3:0]  wr_be;
  logic [8:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;

  logic        a_wr_ready, a_rd_ready, a_rd_valid;
  logic [7:0]  a_rd_data;
  logic [1:0]  a_full_cnt;
  logic        b_wr_ready, b_rd_ready, b_rd_valid;
  logic [31:0] b_rd_data;
  logic [1:0]  b_full_cnt;

  pingpong_dpram #(.W_DATA(8), .N_WORD(512), .N_DELAY(1)) u_a (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_be(wr_be[0:0]), .wr_addr(wr_addr),
    .wr_data(wr_data[7:0]), .wr_done(wr_done), .wr_ready(a_wr_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .full_cnt(a_full_cnt));

  pingpong_dpram #(.W_DATA(32), .N_WORD(512), .N_DELAY(3)) u_b (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_done(wr_done), .wr_ready(b_wr_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .full_cnt(b_full_cnt));

  // Reference model: whole words per {bank, addr}, ownership flags, and pending results by due cycle.
  typedef struct { int due; logic [31:0] d; } pend_t;
  logic [31:0] mm [0:1023];
  logic        mfull [2];
  logic        mws, mrs;
  pend_t       qa[$], qb[$];
  logic [31:0] lasta, lastb;
  int          cyc = 0;
  int          nvec = 0, nerr = 0;

  typedef struct { logic wd; logic rd; logic ewr; logic err; logic [1:0] ecnt; } hs_vec_t;
  hs_vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mfull[0] = 1'b0; mfull[1] = 1'b0; mws = 1'b0; mrs = 1'b0;
    qa.delete(); qb.delete(); lasta = '0; lastb = '0;
  endtask

  task automatic model_edge();
    logic wrdy, rrdy, ows, ors;
    logic [31:0] w;
    if (!rstn) return;
    ows = mws; ors = mrs;
    wrdy = !mfull[ows]; rrdy = mfull[ors];
    if (rd_en && rrdy) begin
      w = mm[{ors, rd_addr}];
      qa.push_back('{cyc, {24'h0, w[7:0]}});
      qb.push_back('{cyc + 2, w});
    end
    if (wr_en && wrdy)
      for (int i = 0; i < 4; i++) if (wr_be[i]) mm[{ows, wr_addr}][8*i +: 8] = wr_data[8*i +: 8];
    if (wr_done && wrdy) begin mfull[ows] = 1'b1; mws = !ows; end
    if (rd_done && rrdy) begin mfull[ors] = 1'b0; mrs = !ors; end
  endtask

  task automatic check_all();
    logic ev_a, ev_b;
    logic [1:0] ecnt;
    ev_a = 1'b0; ev_b = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin ev_a = 1'b1; lasta = qa[0].d; void'(qa.pop_front()); end
    if (qb.size() > 0 && qb[0].due == cyc) begin ev_b = 1'b1; lastb = qb[0].d; void'(qb.pop_front()); end
    ecnt = {1'b0, mfull[0]} + {1'b0, mfull[1]};
    chk("a_rd_valid", {31'h0, a_rd_valid}, {31'h0, ev_a});
    chk("a_rd_data",  {24'h0, a_rd_data}, lasta);
    chk("b_rd_valid", {31'h0, b_rd_valid}, {31'h0, ev_b});
    chk("b_rd_data",  b_rd_data, lastb);
    chk("wr_ready",   {30'h0, a_wr_ready, b_wr_ready}, {30'h0, !mfull[mws], !mfull[mws]});
    chk("rd_ready",   {30'h0, a_rd_ready, b_rd_ready}, {30'h0, mfull[mrs], mfull[mrs]});
    chk("full_cnt",   {28'h0, a_full_cnt, b_full_cnt}, {28'h0, ecnt, ecnt});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    cyc++;
  endtask

  task automatic set_idle();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
    wr_be = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be; tick(); wr_en = 0;
  endtask
  task automatic rd(input logic [8:0] a);
    rd_en = 1; rd_addr = a; tick(); rd_en = 0;
  endtask
  task automatic pulse_wd(); wr_done = 1; tick(); wr_done = 0; endtask
  task automatic pulse_rd(); rd_done = 1; tick(); rd_done = 0; endtask

  initial begin
    int start, firsta, firstb, lastva, cnta, cntb;
    tbl[0] = '{1, 0, 1, 1, 2'd1};
    tbl[1] = '{1, 0, 0, 1, 2'd2};
    tbl[2] = '{1, 0, 0, 1, 2'd2};
    tbl[3] = '{0, 1, 1, 1, 2'd1};
    tbl[4] = '{1, 1, 1, 1, 2'd1};
    tbl[5] = '{0, 1, 1, 0, 2'd0};
    tbl[6] = '{0, 1, 1, 0, 2'd0};
    tbl[7] = '{0, 0, 1, 0, 2'd0};
    tbl[8] = '{1, 0, 1, 1, 2'd1};
    tbl[9] = '{0, 1, 1, 0, 2'd0};
    set_idle();
    model_reset();
    #2;

    // Reset state
    do_reset();
    chk("rst_valid", {31'h0, b_rd_valid}, 32'h0);
    chk("rst_data",  b_rd_data, 32'h0);
    chk("rst_cnt",   {30'h0, b_full_cnt}, 32'h0);
    chk("rst_wrdy",  {31'h0, a_wr_ready}, 32'h1);

    // Ownership handshakes from a hand-derived table
    for (int i = 0; i < 10; i++) begin
      wr_done = tbl[i].wd; rd_done = tbl[i].rd;
      tick();
      chk("tbl_wr_ready", {31'h0, b_wr_ready}, {31'h0, tbl[i].ewr});
      chk("tbl_rd_ready", {31'h0, a_rd_ready}, {31'h0, tbl[i].err});
      chk("tbl_full_cnt", {30'h0, a_full_cnt}, {30'h0, tbl[i].ecnt});
    end
    set_idle();

    // Fill bank0 with addr pattern, hand over
    do_reset();
    for (int a = 0; a < 512; a++) wr(a[8:0], {4{a[7:0]}}, 4'hF);
    pulse_wd();
    chk("fill_wrdy", {31'h0, b_wr_ready}, 32'h1);
    chk("fill_rrdy", {31'h0, b_rd_ready}, 32'h1);
    chk("fill_cnt",  {30'h0, b_full_cnt}, 32'h1);

    // Back-to-back readback on both latencies
    start = cyc; firsta = -1; firstb = -1; lastva = -1; cnta = 0; cntb = 0;
    for (int n = 0; n < 515; n++) begin
      rd_en = (n < 512); rd_addr = n[8:0];
      tick();
      if (a_rd_valid) begin
        if (firsta < 0) firsta = cyc - 1;
        lastva = cyc - 1;
        chk("seq_a_data", {24'h0, a_rd_data}, cnta & 32'hFF);
        cnta++;
      end
      if (b_rd_valid) begin
        if (firstb < 0) firstb = cyc - 1;
        chk("seq_b_data", {24'h0, b_rd_data[7:0]}, cntb & 32'hFF);
        cntb++;
      end
    end
    rd_en = 0;
    chk("seq_a_count", cnta, 512);
    chk("seq_b_count", cntb, 512);
    chk("seq_a_lat",   firsta - start, 0);
    chk("seq_b_lat",   firstb - start, 2);
    chk("seq_a_span",  lastva - firsta, 511);

    // Fill bank1 incl. byte-enable merge; both full
    for (int a = 0; a < 512; a++) wr(a[8:0], $urandom, 4'hF);
    wr(9'd5, 32'hAABBCCDD, 4'hF);
    wr(9'd5, 32'h11223344, 4'b0101);
    pulse_wd();
    chk("both_cnt",  {30'h0, b_full_cnt}, 32'h2);
    chk("both_wrdy", {31'h0, b_wr_ready}, 32'h0);
    wr(9'd0, 32'hFFFFFFFF, 4'hF);
    pulse_rd();
    chk("free_wrdy", {30'h0, a_wr_ready, b_wr_ready}, 32'h3);
    rd(9'd5); tick(); tick();
    chk("be_valid", {31'h0, b_rd_valid}, 32'h1);
    chk("be_data",  b_rd_data, 32'hAA22CC44);
    chk("be_a_hold", {24'h0, a_rd_data}, 32'h44);
    pulse_wd(); pulse_rd();
    rd(9'd0); tick(); tick();
    chk("blocked_wr", b_rd_data, 32'h0);

    // Simultaneous rd_en+rd_done on bank0 with wr_done on bank1
    wr(9'd1, $urandom, 4'hF);
    wr_done = 1; rd_done = 1; rd_en = 1; rd_addr = 9'd7;
    tick();
    set_idle();
    chk("sim_cnt",  {30'h0, b_full_cnt}, 32'h1);
    chk("sim_rrdy", {31'h0, b_rd_ready}, 32'h1);
    chk("sim_a",    {24'h0, a_rd_data}, 32'h07);
    tick(); tick();
    chk("sim_b",    b_rd_data, 32'h07070707);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wr_en = $urandom_range(0, 1); wr_be = 4'($urandom); wr_addr = 9'($urandom);
      wr_data = $urandom; rd_en = $urandom_range(0, 1); rd_addr = 9'($urandom);
      wr_done = ($urandom_range(0, 31) == 0); rd_done = ($urandom_range(0, 31) == 0);
      tick();
    end
    set_idle();

    // Reset with a read in flight
    do_reset();
    wr(9'd3, 32'hDEADBEEF, 4'hF);
    pulse_wd();
    rd(9'd3);
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("mid_cnt",  {30'h0, b_full_cnt}, 32'h0);
    chk("mid_wrdy", {31'h0, b_wr_ready}, 32'h1);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("mid_valid", {31'h0, b_rd_valid}, 32'h0);
    end
    rstn = 1'b1;
    wr(9'd9, 32'h12345678, 4'hF);
    pulse_wd();
    chk("restart_rrdy", {31'h0, b_rd_ready}, 32'h1);
    chk("restart_cnt",  {30'h0, b_full_cnt}, 32'h1);
    rd(9'd9); tick(); tick();
    chk("restart_valid", {31'h0, b_rd_valid}, 32'h1);
    chk("restart_data",  b_rd_data, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
